hamming_scrub_ctrl: RTL and testbench

HAMMING_SCRUB_CTRL -- requirements
Module: hamming_scrub_ctrl

---
 rtl/hamming_scrub_ctrl_pkg.sv | 44 ++++
 rtl/hamming_tmr_path.sv | 17 +
 rtl/hamming_scrub_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hamming_scrub_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_scrub_ctrl_pkg.sv
// rtl/hamming_scrub_ctrl_pkg.sv - shared types, replica indices and Hamming(7,4) helpers
package hamming_scrub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VOTE = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Bit 6 is Hamming position 1, bit 0 is position 7: {p1,p2,d3,p4,d2,d1,d0}
    typedef logic [6:0] codeword_t;

    localparam int REP_0   = 0;
    localparam int REP_1   = 1;
    localparam int REP_2   = 2;
    localparam int NUM_REP = 3;

    function automatic codeword_t hamming_encode(input logic [3:0] d);
        return {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[3],
                d[2] ^ d[1] ^ d[0], d[2], d[1], d[0]};
    endfunction

    function automatic codeword_t hamming_vote(input codeword_t a, input codeword_t b,
                                               input codeword_t c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Syndrome value is the Hamming position (1..7) of a single-bit error
    function automatic logic [2:0] hamming_syndrome(input codeword_t cw);
        return {cw[3] ^ cw[2] ^ cw[1] ^ cw[0],
                cw[5] ^ cw[4] ^ cw[1] ^ cw[0],
                cw[6] ^ cw[4] ^ cw[2] ^ cw[0]};
    endfunction

    function automatic logic [3:0] hamming_decode(input codeword_t cw, input logic [2:0] syn);
        codeword_t fixed;
        fixed = cw;
        if (syn != 3'd0) begin
            fixed[3'd7 - syn] = ~fixed[3'd7 - syn];
        end
        return {fixed[4], fixed[2], fixed[1], fixed[0]};
    endfunction

endpackage

// File: rtl/hamming_tmr_path.sv
// rtl/hamming_tmr_path.sv - combinational vote, syndrome and correction over three replicas
module hamming_tmr_path
    import hamming_scrub_ctrl_pkg::*;
(
    input  logic [6:0] cw0_i,
    input  logic [6:0] cw1_i,
    input  logic [6:0] cw2_i,
    output logic [6:0] voted_o,
    output logic [2:0] syndrome_o,
    output logic [3:0] data_o
);

    assign voted_o    = hamming_vote(cw0_i, cw1_i, cw2_i);
    assign syndrome_o = hamming_syndrome(voted_o);
    assign data_o     = hamming_decode(voted_o, syndrome_o);

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// rtl/hamming_scrub_ctrl.sv - triple-replicated Hamming(7,4) register with voted reads and periodic scrub
module hamming_scrub_ctrl
    import hamming_scrub_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid_i,
    input  logic [3:0]       wr_data_i,
    output logic             wr_ready_o,
    input  logic             rd_req_i,
    output logic             rd_valid_o,
    output logic [3:0]       rd_data_o,
    input  logic             inj_en_i,
    input  logic [1:0]       inj_sel_i,
    input  logic [6:0]       inj_mask_i,
    input  logic [CNT_W-1:0] scrub_period_i,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] err_count_o,
    output logic             busy_o,
    output logic             last_fault_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    codeword_t        rep_q [NUM_REP];
    codeword_t        vote_q;
    logic [2:0]       syn_q;
    logic             mis_q;
    logic             is_rd_q;
    logic [3:0]       rd_data_q;
    logic             last_fault_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] timer_q;
    logic             pend_q;

    logic             do_wr, do_inj, start_rd, start_scrub;
    codeword_t        path_voted, wb_word;
    logic [2:0]       path_syn;
    logic [3:0]       path_data;
    logic             path_mis, fault_now;

    hamming_tmr_path u_path (
        .cw0_i      (rep_q[REP_0]),
        .cw1_i      (rep_q[REP_1]),
        .cw2_i      (rep_q[REP_2]),
        .voted_o    (path_voted),
        .syndrome_o (path_syn),
        .data_o     (path_data)
    );

    assign path_mis  = (rep_q[REP_0] != path_voted) | (rep_q[REP_1] != path_voted)
                     | (rep_q[REP_2] != path_voted);
    assign fault_now = mis_q | (syn_q != 3'd0);
    assign wb_word   = hamming_encode(hamming_decode(vote_q, syn_q));

    assign wr_ready_o   = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign rd_valid_o   = (state_q == ST_WB) & is_rd_q;
    assign rd_data_o    = rd_data_q;
    assign err_count_o  = err_q;
    assign last_fault_o = last_fault_q;

    // Next-state and event decode; IDLE arbitrates write > inject > read > scrub
    always_comb begin
        state_d     = state_q;
        do_wr       = 1'b0;
        do_inj      = 1'b0;
        start_rd    = 1'b0;
        start_scrub = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_valid_i) begin
                    do_wr = 1'b1;
                end else if (inj_en_i) begin
                    do_inj = 1'b1;
                end else if (rd_req_i) begin
                    start_rd = 1'b1;
                    state_d  = ST_VOTE;
                end else if (pend_q) begin
                    start_scrub = 1'b1;
                    state_d     = ST_VOTE;
                end
            end
            ST_VOTE: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Replica storage: host write, fault injection, or corrected write-back; reset value is encode(0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REP; i++) rep_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REP; i++) begin
                if (do_wr)                               rep_q[i] <= hamming_encode(wr_data_i);
                else if (do_inj && inj_sel_i == 2'(i))   rep_q[i] <= rep_q[i] ^ inj_mask_i;
                else if (state_q == ST_WB)               rep_q[i] <= wb_word;
            end
        end
    end

    // Capture vote results in VOTE; read data is presented during the following WB cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q    <= '0;
            syn_q     <= '0;
            mis_q     <= 1'b0;
            is_rd_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            if (start_rd || start_scrub) is_rd_q <= start_rd;
            if (state_q == ST_VOTE) begin
                vote_q <= path_voted;
                syn_q  <= path_syn;
                mis_q  <= path_mis;
                if (is_rd_q) rd_data_q <= path_data;
            end
        end
    end

    // Fault flag and saturating error counter; a clear overrides a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_fault_q <= 1'b0;
            err_q        <= '0;
        end else begin
            if (state_q == ST_WB) last_fault_q <= fault_now;
            if (err_clr_i)
                err_q <= '0;
            else if (state_q == ST_WB && fault_now && err_q != CNT_MAX)
                err_q <= err_q + CNT_W'(1);
        end
    end

    // Scrub timer runs only in IDLE; reaching zero raises a pending scrub and reloads the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            pend_q  <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (start_rd) begin
                timer_q <= scrub_period_i;
                pend_q  <= 1'b0;
            end else begin
                timer_q <= (timer_q <= CNT_W'(1)) ? scrub_period_i : timer_q - CNT_W'(1);
                pend_q  <= (timer_q == CNT_W'(1)) | (pend_q & ~start_scrub);
            end
        end
    end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// tb/tb_hamming_scrub_ctrl.sv - directed self-checking bench for hamming_scrub_ctrl
module tb_hamming_scrub_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_valid, rd_req, inj_en, err_clr;
    logic [3:0]       wr_data;
    logic [1:0]       inj_sel;
    logic [6:0]       inj_mask;
    logic [CNT_W-1:0] scrub_period;
    logic             wr_ready, rd_valid, busy, last_fault;
    logic [3:0]       rd_data;
    logic [CNT_W-1:0] err_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_err  = 0;
    bit saw_valid;
    bit repaired;

    hamming_scrub_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid_i     (wr_valid),
        .wr_data_i      (wr_data),
        .wr_ready_o     (wr_ready),
        .rd_req_i       (rd_req),
        .rd_valid_o     (rd_valid),
        .rd_data_o      (rd_data),
        .inj_en_i       (inj_en),
        .inj_sel_i      (inj_sel),
        .inj_mask_i     (inj_mask),
        .scrub_period_i (scrub_period),
        .err_clr_i      (err_clr),
        .err_count_o    (err_count),
        .busy_o         (busy),
        .last_fault_o   (last_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_inject(input logic [1:0] sel, input logic [6:0] mask);
        inj_en   = 1'b1;
        inj_sel  = sel;
        inj_mask = mask;
        tick();
        inj_en   = 1'b0;
    endtask

    task automatic do_read(input string tag, input bit chk, input logic [3:0] exp_d);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        if (chk) check({tag, "_vote_valid"}, rd_valid, 1'b0);
        tick();
        if (chk) check({tag, "_wb_valid"}, rd_valid, 1'b1);
        if (chk) check({tag, "_wb_data"}, rd_data, exp_d);
        tick();
        if (chk) check({tag, "_idle_valid"}, rd_valid, 1'b0);
    endtask

    task automatic check_reps(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2);
        check({tag, "_rep0"}, dut.rep_q[0], e0);
        check({tag, "_rep1"}, dut.rep_q[1], e1);
        check({tag, "_rep2"}, dut.rep_q[2], e2);
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0; inj_en = 1'b0;
        inj_sel = '0; inj_mask = '0; err_clr = 1'b0; scrub_period = '0;
        tick(); tick();
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_count, 8'd0);
        check("rst_rd_data", rd_data, 4'h0);
        check_reps("rst", 7'h00, 7'h00, 7'h00);
        rst_n = 1'b1;
        tick();

        // Clean write/read of 4'hA
        do_write(4'hA);
        check_reps("wrA", 7'h5A, 7'h5A, 7'h5A);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("rdA_busy", busy, 1'b1);
        check("rdA_wr_ready", wr_ready, 1'b0);
        check("rdA_vote_valid", rd_valid, 1'b0);
        tick();
        check("rdA_wb_valid", rd_valid, 1'b1);
        check("rdA_wb_data", rd_data, 4'hA);
        tick();
        check("rdA_idle_valid", rd_valid, 1'b0);
        check("rdA_err", err_count, 8'd0);
        check("rdA_fault", last_fault, 1'b0);

        // Whole replica corrupted, outvoted by the other two
        do_inject(2'd1, 7'h7F);
        check_reps("inj1", 7'h5A, 7'h25, 7'h5A);
        do_read("rd_tmr", 1'b1, 4'hA);
        check("rd_tmr_err", err_count, 8'd1);
        check("rd_tmr_fault", last_fault, 1'b1);
        check_reps("rd_tmr", 7'h5A, 7'h5A, 7'h5A);

        // Same bit flipped in two replicas: vote carries the error, Hamming fixes it
        do_inject(2'd0, 7'h01);
        do_inject(2'd2, 7'h01);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        check("ham_voted", dut.vote_q, 7'h5B);
        check("ham_syn", dut.syn_q, 3'b111);
        check("ham_data", rd_data, 4'hA);
        tick();
        check("ham_err", err_count, 8'd2);
        check_reps("ham", 7'h5A, 7'h5A, 7'h5A);

        // Priority: write beats inject and read
        wr_valid = 1'b1; wr_data = 4'h3; inj_en = 1'b1; inj_sel = 2'd1; inj_mask = 7'h7F;
        rd_req = 1'b1;
        tick();
        wr_valid = 1'b0; inj_en = 1'b0; rd_req = 1'b0;
        check("pri_wr_busy", busy, 1'b0);
        check_reps("pri_wr", 7'h43, 7'h43, 7'h43);
        // Inject beats read
        inj_en = 1'b1; inj_sel = 2'd0; inj_mask = 7'h01; rd_req = 1'b1;
        tick();
        inj_en = 1'b0; rd_req = 1'b0;
        check("pri_inj_busy", busy, 1'b0);
        check("pri_inj_rep0", dut.rep_q[0], 7'h42);
        // inj_sel=3 touches nothing
        do_inject(2'd3, 7'h7F);
        check_reps("sel3", 7'h42, 7'h43, 7'h43);
        do_read("rd3", 1'b1, 4'h3);
        check("rd3_err", err_count, 8'd3);
        check("rd3_fault", last_fault, 1'b1);
        do_read("rd3_clean", 1'b1, 4'h3);
        check("rd3_clean_err", err_count, 8'd3);
        check("rd3_clean_fault", last_fault, 1'b0);

        // rd_req held high for 6 cycles yields exactly two reads
        exp_err = 0;
        rd_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rd_valid) exp_err++;
        end
        rd_req = 1'b0;
        check("held_pulses", exp_err, 2);
        tick();
        check("held_busy_end", busy, 1'b0);

        // rd_req raised only while busy is not queued
        do_read("noq", 1'b0, 4'h3);
        rd_req = 1'b1;
        tick();
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        check("noq_busy", busy, 1'b0);

        // Autonomous scrub with no host traffic
        scrub_period = 8'd4;
        do_write(4'hA);
        do_inject(2'd0, 7'h10);
        saw_valid = 1'b0;
        repaired  = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (rd_valid) saw_valid = 1'b1;
            if (dut.rep_q[0] == 7'h5A && !busy) begin
                repaired = 1'b1;
                break;
            end
        end
        check("scrub_repaired", repaired, 1'b1);
        check("scrub_no_valid", saw_valid, 1'b0);
        check("scrub_err", err_count, 8'd4);
        scrub_period = 8'd0;
        do_read("scrub_after", 1'b1, 4'hA);

        // err_clr alone, then coincident with an increment
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err", err_count, 8'd0);
        do_inject(2'd1, 7'h7F);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_vs_inc", err_count, 8'd0);

        // Saturation over 300 faulty reads
        exp_err = 0;
        for (int n = 0; n < 300; n++) begin
            do_inject(2'd1, 7'h7F);
            do_read("sat", 1'b0, 4'hA);
            if (exp_err < 255) exp_err++;
        end
        check("sat_err", err_count, exp_err);
        check("sat_fault", last_fault, 1'b1);
        do_inject(2'd2, 7'h7F);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("sat_clr", err_count, 8'd0);

        // Reset during VOTE aborts the read
        do_inject(2'd0, 7'h7F);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rstv_busy", busy, 1'b0);
        check("rstv_valid", rd_valid, 1'b0);
        check("rstv_rd_data", rd_data, 4'h0);
        check_reps("rstv", 7'h00, 7'h00, 7'h00);
        tick();
        check("rstv_valid_hold", rd_valid, 1'b0);
        scrub_period = 8'd3;
        rst_n = 1'b1;

        // First scrub after release: timer loads on the first IDLE cycle, counts down, then scrubs
        for (int k = 0; k < 4; k++) tick();
        check("first_scrub_early", busy, 1'b0);
        tick();
        check("first_scrub_start", busy, 1'b1);
        tick();
        tick();
        check("first_scrub_valid", rd_valid, 1'b0);
        scrub_period = 8'd0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
